// File: rtl/pixel_fifo_writer.sv
// pixel_fifo_writer: streams H_ACTIVE x V_ACTIVE pixels per frame into a FIFO write port.
// Define PIXEL_FIFO_WRITER_SPRITE_EN to compile in the single-colour sprite overlay.
module pixel_fifo_writer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SPRITE_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] src_pixel,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [23:0] sprite_color,
    output logic [23:0] pixel_out,
    output logic        wrreq,
    input  logic        wrfull,
    output logic        new_frame,
    output logic [15:0] frame_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SOF    = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]  state;
    logic [10:0] x;
    logic [10:0] y;
    logic        fire;
    logic        last_x;
    logic        last_y;

    // Handshake is gated by rst so nothing is written in the reset cycle itself.
    always_comb begin
        src_ready = (state == STREAM) && !wrfull && !rst;
        fire      = src_valid && src_ready;
        wrreq     = fire;
        new_frame = (state == SOF) && !rst;
        last_x    = (x == 11'(H_ACTIVE - 1));
        last_y    = (y == 11'(V_ACTIVE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= SOF;
                end
                SOF: begin
                    x     <= '0;
                    y     <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (fire) begin
                        if (last_x) begin
                            x <= '0;
                            if (last_y) begin
                                y           <= '0;
                                frame_count <= frame_count + 16'd1;
                                state       <= enable ? SOF : IDLE;
                            end else begin
                                y <= y + 11'd1;
                            end
                        end else begin
                            x <= x + 11'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIXEL_FIFO_WRITER_SPRITE_EN
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;
    logic [23:0] spr_color;
    logic        in_sprite;

    always_ff @(posedge clk) begin
        if (rst) begin
            spr_x     <= '0;
            spr_y     <= '0;
            spr_color <= '0;
        end else if (state == SOF) begin
            spr_x     <= sprite_x;
            spr_y     <= sprite_y;
            spr_color <= sprite_color;
        end
    end

    // 11-bit bounds keep a sprite near column/row 1023 from wrapping to the origin.
    always_comb begin
        in_sprite = (x >= {1'b0, spr_x}) && (x < ({1'b0, spr_x} + 11'(SPRITE_SIZE))) &&
                    (y >= {1'b0, spr_y}) && (y < ({1'b0, spr_y} + 11'(SPRITE_SIZE)));
        pixel_out = (in_sprite && (spr_color != 24'hFF00FF)) ? spr_color : src_pixel;
    end
`else
    logic unused_sprite;

    always_comb begin
        unused_sprite = ^{sprite_x, sprite_y, sprite_color};
        pixel_out     = src_pixel;
    end
`endif

endmodule

// File: doc/pixel_fifo_writer.md
PIXEL_FIFO_WRITER -- requirements
Module: pixel_fifo_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 SHALL have parameter SPRITE_SIZE, default 16, meaning square sprite edge length in pixels.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port enable, input, 1, frame streaming permitted.
REQ-007 SHALL have port src_pixel, input, 24, upstream RGB888 pixel {R,G,B}.
REQ-008 SHALL have port src_valid, input, 1, src_pixel holds a valid pixel.
REQ-009 SHALL have port src_ready, output, 1, block accepts src_pixel this cycle.
REQ-010 SHALL have port sprite_x, input, 10, sprite left column, sampled at frame start.
REQ-011 SHALL have port sprite_y, input, 10, sprite top row, sampled at frame start.
REQ-012 SHALL have port sprite_color, input, 24, sprite colour, sampled at frame start.
REQ-013 SHALL have port pixel_out, output, 24, pixel to dual-clock FIFO data.
REQ-014 SHALL have port wrreq, output, 1, FIFO write request.
REQ-015 SHALL have port wrfull, input, 1, FIFO write-side full.
REQ-016 SHALL have port new_frame, output, 1, one-cycle pulse at start of each frame.
REQ-017 SHALL have port frame_count, output, 16, completed-frame counter.

Function
REQ-018 FSM states SHALL be IDLE, SOF, STREAM.
REQ-019 IDLE -> SOF when enable=1; otherwise stay in IDLE.
REQ-020 SOF SHALL last exactly one cycle: assert new_frame, latch sprite_x/y/color, clear x/y counters, then go to STREAM.
REQ-021 In STREAM, src_ready SHALL equal !wrfull; src_ready=0 in IDLE and SOF.
REQ-022 A transfer (fire) SHALL occur when src_valid && src_ready; wrreq SHALL equal fire combinationally (zero latency), so no write is ever issued while wrfull=1.
REQ-023 On each fire, x SHALL increment; at x=H_ACTIVE-1, x wraps to 0 and y increments.
REQ-024 On the fire at x=H_ACTIVE-1, y=V_ACTIVE-1: frame_count increments (wraps at 16'hFFFF -> 0); next state is SOF if enable=1, else IDLE.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes before returning to IDLE.
REQ-026 wrfull rising mid-frame SHALL stall counters and src_ready with no pixel lost or duplicated.
REQ-027 pixel_out SHALL equal the latched sprite colour when latched_x <= x < latched_x+SPRITE_SIZE and latched_y <= y < latched_y+SPRITE_SIZE, compared in 11-bit arithmetic (no wrap), otherwise src_pixel.
REQ-028 Sprite colour 24'hFF00FF SHALL be transparent (src_pixel passes through).
REQ-029 Sprite regions extending beyond H_ACTIVE/V_ACTIVE SHALL be clipped implicitly; no wrap to opposite edge.
REQ-030 Sprite inputs changed mid-frame SHALL take effect only at the next SOF.

Reset
REQ-031 While rst=1 at a clock edge: state=IDLE, x=y=0, frame_count=0, latched sprite regs=0, new_frame=0.
REQ-032 src_ready and wrreq SHALL be 0 during reset; rst mid-frame abandons the frame with no further writes.

Configuration
REQ-033 Macro PIXEL_FIFO_WRITER_SPRITE_EN defined: sprite overlay per REQ-027..030 compiled in.
REQ-034 Macro undefined: pixel_out=src_pixel always; sprite inputs ignored, no latch registers; all other behaviour identical.

Verification
REQ-035 rst then enable=1, src_valid=1 constant, wrfull=0 -> new_frame pulses once, exactly 307200 wrreq cycles, one SOF gap cycle, frame_count=1.
REQ-036 wrfull=1 for 10 cycles at x=100,y=5 -> wrreq=0 and src_ready=0 during stall; resumes at x=100; total pixels per frame remains 307200.
REQ-037 Sprite enabled, sprite_x=630, sprite_y=470, colour 24'h00FF00, src_pixel=24'h123456 -> green at x 630..639, y 470..479 only (100 pixels); none at x 0..5.
REQ-038 sprite_color=24'hFF00FF -> pixel_out equals src_pixel for all 307200 pixels.
REQ-039 enable dropped at y=200 -> frame completes, FSM returns to IDLE, no new_frame until enable=1 again.
REQ-040 rst asserted at y=300 -> next cycle wrreq=0, src_ready=0, frame_count=0; after release and enable, frame restarts at x=0,y=0.
